clint_ctrl: RTL
===============

CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 Parameter: TIMER_EN, default 1, 1 enables the mtime/mtimecmp timer interrupt source; 0 ties the timer-pending condition to 0.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 inst_i  input  32  instruction currently in EX.
REQ-005 inst_addr_i  input  64  PC of inst_i.
REQ-006 inst_valid_i  input  1  inst_i/inst_addr_i valid this cycle.
REQ-007 mepc_i, mtvec_i, mstatus_i  input  64 each  current CSR values from the CSR file.
REQ-008 mtimecmp_wen_i  input  1  write strobe for mtimecmp.
REQ-009 mtimecmp_wdata_i  input  64  new mtimecmp value.
REQ-010 csr_wen_o  output  1  writes mepc_o/mcause_o/mstatus_o into the CSR file at the next posedge.
REQ-011 mepc_o, mcause_o, mstatus_o  output  64 each  CSR write data.
REQ-012 int_assert_o  output  1  redirect the PC to int_addr_o; also flushes younger instructions.
REQ-013 int_addr_o  output  64  redirect target.
REQ-014 hold_flag_o  output  1  stall the pipeline.
REQ-015 mtime_o  output  64  current mtime.

Function
REQ-016 Decode, only when inst_valid_i=1:
- ECALL = 32'h00000073
- EBREAK = 32'h00100073
- MRET = 32'h30200073
REQ-017 Timer pending (TP) = TIMER_EN & (mtime >= mtimecmp, unsigned) & mstatus_i[3] (MIE) & inst_valid_i.
REQ-018 FSM states: IDLE, TRAP, RET, JUMP; reset state IDLE.
REQ-019 In IDLE, events are evaluated in priority order TP > ECALL/EBREAK > MRET; only the highest event is taken.
REQ-020 Trap entry (TP, ECALL or EBREAK taken in IDLE): capture pc = inst_addr_i and cause; next state TRAP.
- Cause: TP = 64'h8000_0000_0000_0007; ECALL = 64'd11; EBREAK = 64'd3.
REQ-021 MRET taken in IDLE: capture target = mepc_i; next state RET.
REQ-022 TRAP, one cycle:
- csr_wen_o=1, mepc_o=captured pc, mcause_o=captured cause.
- mstatus_o = mstatus_i with bit7 (MPIE) set to mstatus_i[3], bit3 (MIE) cleared, bits[12:11] (MPP) = 2'b11, all other bits unchanged.
- Next state JUMP, target = {mtvec_i[63:2], 2'b00}.
REQ-023 RET, one cycle:
- csr_wen_o=1, mepc_o=mepc_i, mcause_o=last cause register.
- mstatus_o = mstatus_i with MIE set to mstatus_i[7], MPIE=1, MPP=2'b00.
- Next state JUMP.
REQ-024 JUMP, one cycle: int_assert_o=1, int_addr_o=target; next state IDLE.
REQ-025 The last cause register updates on every trap entry; its reset value is 0.
REQ-026 hold_flag_o = (state != IDLE) | (an event is taken this cycle in IDLE), combinational.
REQ-027 Outside TRAP/RET: csr_wen_o=0, mepc_o=mcause_o=mstatus_o=0.
REQ-028 Outside JUMP: int_assert_o=0, int_addr_o=0.
REQ-029 Events arriving while state != IDLE are ignored, not queued.
REQ-030 mtime increments by 1 every cycle (when TIMER_EN=1); it wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-031 mtimecmp loads mtimecmp_wdata_i on mtimecmp_wen_i. The compare in the same cycle uses the old mtimecmp value.
REQ-032 A trapped instruction is not retired; the handler returns to the same PC (ECALL advancing is software's duty).
REQ-033 Latency: event cycle N -> CSR write at N+1 -> redirect at N+2 -> IDLE at N+3.

Reset
REQ-034 When rst=0 at a posedge:
- state=IDLE, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, last cause=0, captured pc/target=0.
REQ-035 While rst=0, every output is 0 combinationally.
REQ-036 Reset during TRAP/RET/JUMP aborts the sequence: no CSR write and no redirect after release.

Verification
REQ-037 ECALL at pc 0x8000_0010, mtvec_i=0x8000_0100, mstatus_i=0x8 -> N+1: csr_wen_o=1, mepc_o=0x8000_0010, mcause_o=11, mstatus_o=0x1880; N+2: int_assert_o=1, int_addr_o=0x8000_0100.
REQ-038 MRET with mepc_i=0x8000_0014, mstatus_i=0x1880 -> N+1: mstatus_o=0x88, mcause_o=11; N+2: int_addr_o=0x8000_0014.
REQ-039 Write mtimecmp=20 at cycle 5, MIE=1, continuous valid instructions -> trap taken in the first cycle mtime>=20 with mcause_o=0x8000_0000_0000_0007 and mepc_o=that cycle's inst_addr_i; with MIE=0 -> no trap.
REQ-040 TP and EBREAK in the same cycle -> timer cause taken; EBREAK issued during TRAP -> ignored; hold_flag_o high for 3 cycles.
REQ-041 rst=0 asserted in TRAP state -> next cycles csr_wen_o=0, int_assert_o=0, mtime_o=0.
REQ-042 Force mtime to 64'hFFFF_FFFF_FFFF_FFFE -> reads ...FFFF, then 0, then 1 on consecutive cycles.

Source files
------------

// File: rtl/clint_ctrl_if.sv
// clint_ctrl_if
// Bundles the pipeline-facing and CSR-facing signals of the core-local
// interrupt controller so the controller and its user share one port.
//
// Signals (directions as seen from the controller, i.e. the slave side):
//   inst_i            in   32  instruction currently in EX
//   inst_addr_i       in   64  PC of inst_i
//   inst_valid_i      in    1  inst_i / inst_addr_i valid this cycle
//   mepc_i            in   64  current mepc from the CSR file
//   mtvec_i           in   64  current mtvec from the CSR file
//   mstatus_i         in   64  current mstatus from the CSR file
//   mtimecmp_wen_i    in    1  write strobe for mtimecmp
//   mtimecmp_wdata_i  in   64  new mtimecmp value
//   csr_wen_o         out   1  write mepc_o/mcause_o/mstatus_o at next posedge
//   mepc_o            out  64  CSR write data
//   mcause_o          out  64  CSR write data
//   mstatus_o         out  64  CSR write data
//   int_assert_o      out   1  redirect PC to int_addr_o, flush younger insts
//   int_addr_o        out  64  redirect target
//   hold_flag_o       out   1  stall the pipeline
//   mtime_o           out  64  current mtime
//
// Modports: master drives the inputs (core side), slave is the controller.
interface clint_ctrl_if;
    logic [31:0] inst_i;
    logic [63:0] inst_addr_i;
    logic        inst_valid_i;
    logic [63:0] mepc_i;
    logic [63:0] mtvec_i;
    logic [63:0] mstatus_i;
    logic        mtimecmp_wen_i;
    logic [63:0] mtimecmp_wdata_i;

    logic        csr_wen_o;
    logic [63:0] mepc_o;
    logic [63:0] mcause_o;
    logic [63:0] mstatus_o;
    logic        int_assert_o;
    logic [63:0] int_addr_o;
    logic        hold_flag_o;
    logic [63:0] mtime_o;

    modport master (
        output inst_i, inst_addr_i, inst_valid_i,
        output mepc_i, mtvec_i, mstatus_i,
        output mtimecmp_wen_i, mtimecmp_wdata_i,
        input  csr_wen_o, mepc_o, mcause_o, mstatus_o,
        input  int_assert_o, int_addr_o, hold_flag_o, mtime_o
    );

    modport slave (
        input  inst_i, inst_addr_i, inst_valid_i,
        input  mepc_i, mtvec_i, mstatus_i,
        input  mtimecmp_wen_i, mtimecmp_wdata_i,
        output csr_wen_o, mepc_o, mcause_o, mstatus_o,
        output int_assert_o, int_addr_o, hold_flag_o, mtime_o
    );
endinterface

// File: rtl/clint_ctrl.sv
// clint_ctrl
// Core-local interrupt controller: takes machine-mode traps (timer interrupt,
// ECALL, EBREAK) and MRET returns from the instruction in EX, writes the trap
// CSRs one cycle later and redirects the PC one cycle after that. Also owns
// the mtime counter and the mtimecmp compare register.
//
// Ports:
//   clk  in  1  clock, all state updates on posedge
//   rst  in  1  synchronous, active-low reset; forces all outputs to 0
//   bus  clint_ctrl_if.slave  instruction, CSR and timer signals
// Parameter:
//   TIMER_EN  1 enables the mtime/mtimecmp interrupt source, 0 disables it
module clint_ctrl #(
    parameter int TIMER_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    clint_ctrl_if.slave  bus
);

    localparam bit          TIMER_ON    = (TIMER_EN != 0);
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CAUSE_ECALL = 64'd11;
    localparam logic [63:0] CAUSE_BREAK = 64'd3;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        RET,
        JUMP
    } state_t;

    state_t      state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] last_cause;
    logic [63:0] cap_pc;
    logic [63:0] target;

    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
    logic        timer_pend;
    logic        take_trap;
    logic        take_ret;
    logic [63:0] trap_cause;

    // Event decode. The timer compare sees the mtimecmp value from before any
    // write happening this cycle. Only one event is accepted per idle cycle,
    // timer first, then ECALL/EBREAK, then MRET.
    always_comb begin
        is_ecall   = bus.inst_valid_i && (bus.inst_i == INST_ECALL);
        is_ebreak  = bus.inst_valid_i && (bus.inst_i == INST_EBREAK);
        is_mret    = bus.inst_valid_i && (bus.inst_i == INST_MRET);
        timer_pend = TIMER_ON && (mtime >= mtimecmp) && bus.mstatus_i[3]
                     && bus.inst_valid_i;
        take_trap  = (state == IDLE) && (timer_pend || is_ecall || is_ebreak);
        take_ret   = (state == IDLE) && !take_trap && is_mret;
        if (timer_pend) begin
            trap_cause = CAUSE_TIMER;
        end else if (is_ecall) begin
            trap_cause = CAUSE_ECALL;
        end else begin
            trap_cause = CAUSE_BREAK;
        end
    end

    // Trap/return sequencer. The trap target is latched while in TRAP so the
    // redirect uses the mtvec seen on the CSR-write cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_cause <= 64'd0;
            cap_pc     <= 64'd0;
            target     <= 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_trap) begin
                        cap_pc     <= bus.inst_addr_i;
                        last_cause <= trap_cause;
                        state      <= TRAP;
                    end else if (take_ret) begin
                        target <= bus.mepc_i;
                        state  <= RET;
                    end
                end
                TRAP: begin
                    target <= bus.mtvec_i & ~64'd3;
                    state  <= JUMP;
                end
                RET: begin
                    state <= JUMP;
                end
                JUMP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running machine timer and its compare register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (TIMER_ON) begin
                mtime <= mtime + 64'd1;
            end
            if (bus.mtimecmp_wen_i) begin
                mtimecmp <= bus.mtimecmp_wdata_i;
            end
        end
    end

    // Outputs follow the current state; reset forces everything low at once.
    // Trap entry saves MIE into MPIE, clears MIE and sets MPP to machine mode;
    // MRET restores MIE from MPIE, sets MPIE and drops MPP to user.
    always_comb begin
        bus.csr_wen_o    = 1'b0;
        bus.mepc_o       = 64'd0;
        bus.mcause_o     = 64'd0;
        bus.mstatus_o    = 64'd0;
        bus.int_assert_o = 1'b0;
        bus.int_addr_o   = 64'd0;
        bus.hold_flag_o  = 1'b0;
        bus.mtime_o      = 64'd0;
        if (rst) begin
            bus.hold_flag_o = (state != IDLE) || take_trap || take_ret;
            bus.mtime_o     = mtime;
            unique case (state)
                TRAP: begin
                    bus.csr_wen_o        = 1'b1;
                    bus.mepc_o           = cap_pc;
                    bus.mcause_o         = last_cause;
                    bus.mstatus_o        = bus.mstatus_i;
                    bus.mstatus_o[7]     = bus.mstatus_i[3];
                    bus.mstatus_o[3]     = 1'b0;
                    bus.mstatus_o[12:11] = 2'b11;
                end
                RET: begin
                    bus.csr_wen_o        = 1'b1;
                    bus.mepc_o           = bus.mepc_i;
                    bus.mcause_o         = last_cause;
                    bus.mstatus_o        = bus.mstatus_i;
                    bus.mstatus_o[3]     = bus.mstatus_i[7];
                    bus.mstatus_o[7]     = 1'b1;
                    bus.mstatus_o[12:11] = 2'b00;
                end
                JUMP: begin
                    bus.int_assert_o = 1'b1;
                    bus.int_addr_o   = target;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
